// File: rtl/mul_arb_pkg.sv
// mul_arb_pkg: shared state encoding and datapath widths for the multiplier arbiter
package mul_arb_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  localparam int OP_W  = 4;
  localparam int RES_W = 8;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin winner select starting at ptr_i
module rr_pick #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req_i,
  input  logic [$clog2(N_REQ)-1:0] ptr_i,
  output logic [N_REQ-1:0]         gnt_o,
  output logic [$clog2(N_REQ)-1:0] idx_o
);
  localparam int ID_W = $clog2(N_REQ);
  logic [ID_W-1:0] k;
  // scan offsets from farthest to nearest so the request closest to ptr_i wins
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    k = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      k = ID_W'((int'(ptr_i) + i) % N_REQ);
      if (req_i[k]) begin
        gnt_o = '0;
        gnt_o[k] = 1'b1;
        idx_o = k;
      end
    end
  end
endmodule

// File: rtl/mul_arbiter.sv
// mul_arbiter: round-robin sharing of one multiplier with a tagged response bus
module mul_arbiter import mul_arb_pkg::*; #(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [N_REQ-1:0]          req_valid_i,
  input  logic [OP_W*N_REQ-1:0]     req_a_i,
  input  logic [OP_W*N_REQ-1:0]     req_b_i,
  output logic [N_REQ-1:0]          req_ready_o,
  output logic                      rsp_valid_o,
  input  logic                      rsp_ready_i,
  output logic [$clog2(N_REQ)-1:0]  rsp_id_o,
  output logic [RES_W-1:0]          rsp_result_o,
  output logic                      rsp_err_o,
  output logic                      mul_start_o,
  output logic [OP_W-1:0]           mul_a_o,
  output logic [OP_W-1:0]           mul_b_o,
  input  logic                      mul_valid_i,
  input  logic [RES_W-1:0]          mul_result_i
);
  localparam int ID_W = $clog2(N_REQ);
  localparam int WD_W = $clog2(TIMEOUT + 1);
  state_t state, state_n;
  logic [ID_W-1:0] rr_ptr, id_q, win;
  logic [N_REQ-1:0] gnt;
  logic [OP_W-1:0] a_q, b_q;
  logic [RES_W-1:0] res_q;
  logic err_q, accept, done, tmo;
  logic [WD_W-1:0] wd;
  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req_i(req_valid_i),
    .ptr_i(rr_ptr),
    .gnt_o(gnt),
    .idx_o(win)
  );
  assign accept = (state == IDLE) && |req_valid_i;
  assign done = (state == WAIT) && mul_valid_i;
  assign tmo = (state == WAIT) && !mul_valid_i && (wd == WD_W'(TIMEOUT - 1));
  assign rsp_id_o = id_q;
  assign rsp_result_o = res_q;
  assign rsp_err_o = err_q;
  assign mul_a_o = a_q;
  assign mul_b_o = b_q;
  // next state and handshake outputs decoded from the current state
  always_comb begin
    state_n = state;
    req_ready_o = '0;
    mul_start_o = 1'b0;
    rsp_valid_o = 1'b0;
    case (state)
      IDLE: begin
        state_n = accept ? ISSUE : IDLE;
        req_ready_o = rst_i ? '0 : gnt;
      end
      ISSUE: begin
        state_n = WAIT;
        mul_start_o = 1'b1;
      end
      WAIT: state_n = (done || tmo) ? RESP : WAIT;
      RESP: begin
        state_n = rsp_ready_i ? IDLE : RESP;
        rsp_valid_o = 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end
  // state, transaction registers and saturating watchdog
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
      rr_ptr <= '0;
      id_q <= '0;
      a_q <= '0;
      b_q <= '0;
      res_q <= '0;
      err_q <= 1'b0;
      wd <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        id_q <= win;
        a_q <= req_a_i[OP_W*win +: OP_W];
        b_q <= req_b_i[OP_W*win +: OP_W];
        rr_ptr <= (win == ID_W'(N_REQ - 1)) ? '0 : win + ID_W'(1);
        res_q <= '0;
        err_q <= 1'b0;
      end
      if (done) begin
        res_q <= mul_result_i;
        err_q <= 1'b0;
      end else if (tmo) begin
        res_q <= '0;
        err_q <= 1'b1;
      end
      if (state == ISSUE) wd <= '0;
      else if (state == WAIT && wd != WD_W'(TIMEOUT)) wd <= wd + WD_W'(1);
    end
  end
endmodule

// File: tb/tb_mul_arbiter.sv
// tb_mul_arbiter: directed scenarios against a 5-cycle behavioural multiplier
module tb_mul_arbiter;
  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  logic [3:0] req_valid_i = '0;
  logic [15:0] req_a_i = '0;
  logic [15:0] req_b_i = '0;
  logic [3:0] req_ready_o;
  logic rsp_valid_o;
  logic rsp_ready_i = 1'b1;
  logic [1:0] rsp_id_o;
  logic [7:0] rsp_result_o;
  logic rsp_err_o;
  logic mul_start_o;
  logic [3:0] mul_a_o, mul_b_o;
  logic mul_valid_i;
  logic [7:0] mul_result_i;
  logic [2:0] m_cnt;
  logic m_valid;
  logic mul_dis = 1'b0;
  int tests = 0;
  int fails = 0;

  mul_arbiter #(.N_REQ(4), .TIMEOUT(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_a_i(req_a_i), .req_b_i(req_b_i),
    .req_ready_o(req_ready_o),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_id_o(rsp_id_o), .rsp_result_o(rsp_result_o), .rsp_err_o(rsp_err_o),
    .mul_start_o(mul_start_o), .mul_a_o(mul_a_o), .mul_b_o(mul_b_o),
    .mul_valid_i(mul_valid_i), .mul_result_i(mul_result_i)
  );

  always #5 clk_i = ~clk_i;

  // multiplier: valid rises 5 cycles after start and stays high until the next start
  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      m_cnt <= '0;
      m_valid <= 1'b0;
      mul_result_i <= '0;
    end else if (mul_start_o) begin
      m_cnt <= 3'd5;
      m_valid <= 1'b0;
    end else begin
      if (m_cnt != 0) m_cnt <= m_cnt - 3'd1;
      if (m_cnt == 3'd2) begin
        m_valid <= 1'b1;
        mul_result_i <= mul_a_o * mul_b_o;
      end
    end
  end
  assign mul_valid_i = m_valid & ~mul_dis;

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset;
    req_valid_i = 4'b1111;
    #2;
    tests++; if (req_ready_o !== 4'b0000) begin fails++; $display("FAIL reset_ready got %b want 0000", req_ready_o); end
    tests++; if (rsp_valid_o !== 1'b0 || mul_start_o !== 1'b0) begin fails++; $display("FAIL reset_valid got rsp=%b start=%b want 0 0", rsp_valid_o, mul_start_o); end
    tests++; if ({rsp_id_o, rsp_result_o, rsp_err_o, mul_a_o, mul_b_o} !== 19'd0) begin fails++; $display("FAIL reset_regs got id=%0d res=%0d err=%b a=%0d b=%0d want 0", rsp_id_o, rsp_result_o, rsp_err_o, mul_a_o, mul_b_o); end
    req_valid_i = '0;
    tick();
    tick();
    rst_i = 1'b0;
    tick();
  endtask

  task automatic test_fairness;
    int exp_id[5] = '{0, 1, 2, 3, 0};
    int exp_res[5] = '{3, 6, 9, 12, 3};
    rsp_ready_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      req_a_i[4*k +: 4] = 4'(k + 1);
      req_b_i[4*k +: 4] = 4'd3;
    end
    req_valid_i = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      #1;
      tests++; if (req_ready_o !== 4'(1 << exp_id[n])) begin fails++; $display("FAIL fair_grant%0d got %b want %b", n, req_ready_o, 4'(1 << exp_id[n])); end
      tick();
      tick();
      tick();
      tests++; if (req_ready_o !== 4'b0000) begin fails++; $display("FAIL fair_busy_ready%0d got %b want 0000", n, req_ready_o); end
      repeat (4) tick();
      tests++; if (rsp_valid_o !== 1'b1 || rsp_id_o !== 2'(exp_id[n]) || rsp_result_o !== 8'(exp_res[n])) begin fails++; $display("FAIL fair_rsp%0d got v=%b id=%0d res=%0d want 1 %0d %0d", n, rsp_valid_o, rsp_id_o, rsp_result_o, exp_id[n], exp_res[n]); end
      if (n == 4) req_valid_i = '0;
      tick();
    end
    #1;
    tests++; if (req_ready_o !== 4'b0000 || rsp_valid_o !== 1'b0) begin fails++; $display("FAIL fair_idle got ready=%b v=%b want 0000 0", req_ready_o, rsp_valid_o); end
  endtask

  task automatic test_single;
    req_a_i[11:8] = 4'd7;
    req_b_i[11:8] = 4'd9;
    req_valid_i = 4'b0100;
    #1;
    tests++; if (req_ready_o !== 4'b0100 || mul_start_o !== 1'b0) begin fails++; $display("FAIL single_grant got ready=%b start=%b want 0100 0", req_ready_o, mul_start_o); end
    tick();
    req_valid_i = '0;
    #1;
    tests++; if (mul_start_o !== 1'b1 || mul_a_o !== 4'd7 || mul_b_o !== 4'd9) begin fails++; $display("FAIL single_issue got start=%b a=%0d b=%0d want 1 7 9", mul_start_o, mul_a_o, mul_b_o); end
    for (int c = 2; c <= 6; c++) begin
      tick();
      tests++; if (mul_start_o !== 1'b0 || rsp_valid_o !== 1'b0) begin fails++; $display("FAIL single_wait%0d got start=%b v=%b want 0 0", c, mul_start_o, rsp_valid_o); end
    end
    tick();
    tests++; if (rsp_valid_o !== 1'b1 || rsp_id_o !== 2'd2 || rsp_result_o !== 8'd63 || rsp_err_o !== 1'b0) begin fails++; $display("FAIL single_rsp got v=%b id=%0d res=%0d err=%b want 1 2 63 0", rsp_valid_o, rsp_id_o, rsp_result_o, rsp_err_o); end
    tick();
    tests++; if (rsp_valid_o !== 1'b0) begin fails++; $display("FAIL single_done got v=%b want 0", rsp_valid_o); end
  endtask

  task automatic test_backpressure;
    rsp_ready_i = 1'b0;
    req_a_i[3:0] = 4'd15;
    req_b_i[3:0] = 4'd15;
    req_valid_i = 4'b0001;
    #1;
    tests++; if (req_ready_o !== 4'b0001) begin fails++; $display("FAIL bp_grant got %b want 0001", req_ready_o); end
    tick();
    req_valid_i = 4'b1010;
    repeat (6) tick();
    for (int i = 0; i < 10; i++) begin
      tests++; if (rsp_valid_o !== 1'b1 || rsp_id_o !== 2'd0 || rsp_result_o !== 8'd225 || rsp_err_o !== 1'b0 || req_ready_o !== 4'b0000) begin fails++; $display("FAIL bp_hold%0d got v=%b id=%0d res=%0d err=%b ready=%b want 1 0 225 0 0000", i, rsp_valid_o, rsp_id_o, rsp_result_o, rsp_err_o, req_ready_o); end
      tick();
    end
    req_valid_i = '0;
    rsp_ready_i = 1'b1;
    #1;
    tests++; if (rsp_valid_o !== 1'b1 || rsp_result_o !== 8'd225) begin fails++; $display("FAIL bp_release got v=%b res=%0d want 1 225", rsp_valid_o, rsp_result_o); end
    tick();
    tests++; if (rsp_valid_o !== 1'b0) begin fails++; $display("FAIL bp_done got v=%b want 0", rsp_valid_o); end
  endtask

  task automatic test_timeout;
    mul_dis = 1'b1;
    req_a_i[7:4] = 4'd5;
    req_b_i[7:4] = 4'd5;
    req_valid_i = 4'b0010;
    #1;
    tests++; if (req_ready_o !== 4'b0010) begin fails++; $display("FAIL tmo_grant got %b want 0010", req_ready_o); end
    tick();
    req_valid_i = '0;
    repeat (16) tick();
    tests++; if (rsp_valid_o !== 1'b0) begin fails++; $display("FAIL tmo_early got v=%b want 0 in cycle 17", rsp_valid_o); end
    tick();
    tests++; if (rsp_valid_o !== 1'b1 || rsp_err_o !== 1'b1 || rsp_result_o !== 8'd0 || rsp_id_o !== 2'd1) begin fails++; $display("FAIL tmo_rsp got v=%b err=%b res=%0d id=%0d want 1 1 0 1", rsp_valid_o, rsp_err_o, rsp_result_o, rsp_id_o); end
    tick();
    tests++; if (rsp_valid_o !== 1'b0) begin fails++; $display("FAIL tmo_done got v=%b want 0", rsp_valid_o); end
    mul_dis = 1'b0;
  endtask

  task automatic test_reset_wait;
    int seen;
    req_a_i[15:12] = 4'd6;
    req_b_i[15:12] = 4'd7;
    req_valid_i = 4'b1000;
    #1;
    tests++; if (req_ready_o !== 4'b1000) begin fails++; $display("FAIL rw_grant got %b want 1000", req_ready_o); end
    tick();
    req_valid_i = '0;
    tick();
    tick();
    rst_i = 1'b1;
    #1;
    tests++; if ({req_ready_o, rsp_valid_o, rsp_id_o, rsp_result_o, rsp_err_o, mul_start_o, mul_a_o, mul_b_o} !== 25'd0) begin fails++; $display("FAIL rw_outputs got ready=%b v=%b id=%0d res=%0d err=%b start=%b a=%0d b=%0d want 0", req_ready_o, rsp_valid_o, rsp_id_o, rsp_result_o, rsp_err_o, mul_start_o, mul_a_o, mul_b_o); end
    tick();
    rst_i = 1'b0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (rsp_valid_o) seen++;
    end
    tests++; if (seen !== 0) begin fails++; $display("FAIL rw_no_rsp got %0d response cycles want 0", seen); end
    req_a_i[3:0] = 4'd2;
    req_b_i[3:0] = 4'd5;
    req_valid_i = 4'b0001;
    #1;
    tests++; if (req_ready_o !== 4'b0001) begin fails++; $display("FAIL rw_regrant got %b want 0001", req_ready_o); end
    tick();
    req_valid_i = '0;
    repeat (6) tick();
    tests++; if (rsp_valid_o !== 1'b1 || rsp_id_o !== 2'd0 || rsp_result_o !== 8'd10 || rsp_err_o !== 1'b0) begin fails++; $display("FAIL rw_rsp got v=%b id=%0d res=%0d err=%b want 1 0 10 0", rsp_valid_o, rsp_id_o, rsp_result_o, rsp_err_o); end
    tick();
  endtask

  task automatic test_back_to_back;
    req_a_i[11:8] = 4'd7;
    req_b_i[11:8] = 4'd9;
    req_valid_i = 4'b0100;
    #1;
    tests++; if (req_ready_o !== 4'b0100) begin fails++; $display("FAIL b2b_grant1 got %b want 0100", req_ready_o); end
    tick();
    req_a_i[7:4] = 4'd3;
    req_b_i[7:4] = 4'd4;
    req_valid_i = 4'b0010;
    repeat (6) tick();
    tests++; if (rsp_valid_o !== 1'b1 || rsp_result_o !== 8'd63 || rsp_id_o !== 2'd2) begin fails++; $display("FAIL b2b_rsp1 got v=%b res=%0d id=%0d want 1 63 2", rsp_valid_o, rsp_result_o, rsp_id_o); end
    tick();
    tests++; if (req_ready_o !== 4'b0010 || mul_valid_i !== 1'b1) begin fails++; $display("FAIL b2b_grant2 got ready=%b mulv=%b want 0010 1", req_ready_o, mul_valid_i); end
    tick();
    req_valid_i = '0;
    #1;
    tests++; if (mul_start_o !== 1'b1 || mul_valid_i !== 1'b1 || mul_a_o !== 4'd3 || mul_b_o !== 4'd4) begin fails++; $display("FAIL b2b_issue got start=%b mulv=%b a=%0d b=%0d want 1 1 3 4", mul_start_o, mul_valid_i, mul_a_o, mul_b_o); end
    tick();
    tests++; if (rsp_valid_o !== 1'b0) begin fails++; $display("FAIL b2b_stale got v=%b res=%0d want v=0", rsp_valid_o, rsp_result_o); end
    repeat (5) tick();
    tests++; if (rsp_valid_o !== 1'b1 || rsp_result_o !== 8'd12 || rsp_id_o !== 2'd1 || rsp_err_o !== 1'b0) begin fails++; $display("FAIL b2b_rsp2 got v=%b res=%0d id=%0d err=%b want 1 12 1 0", rsp_valid_o, rsp_result_o, rsp_id_o, rsp_err_o); end
    tick();
  endtask

  initial begin
    test_reset();
    test_fairness();
    test_single();
    test_backpressure();
    test_timeout();
    test_reset_wait();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
